// File: rtl/vreg_elem_sequencer.sv
// Element sequencer: walks one vector element per cycle through read ports 0/1 and a
// fixed-latency ALU, then writes each result back through port 2 after LAT cycles.
module vreg_elem_sequencer #(
    parameter int W   = 16,
    parameter int L   = 32,
    parameter int A   = 5,
    parameter int LAT = 2
) (
    input  logic         clk,
    input  logic         n_reset,
    input  logic         start,
    input  logic [A-1:0] vs1_base,
    input  logic [A-1:0] vs2_base,
    input  logic [A-1:0] vd_base,
    input  logic [A:0]   vl,
    output logic         busy,
    output logic         done,
    output logic [A-1:0] rf_addr0,
    output logic [A-1:0] rf_addr1,
    output logic         rf_write0,
    output logic         rf_write1,
    input  logic [W-1:0] rf_rdata0,
    input  logic [W-1:0] rf_rdata1,
    output logic [A-1:0] rf_addr2,
    output logic         rf_write2,
    output logic [W-1:0] rf_wdata2,
    output logic [W-1:0] alu_a,
    output logic [W-1:0] alu_b,
    output logic         alu_valid,
    input  logic [W-1:0] alu_result
);

    localparam logic [A:0] VL_MAX = (A+1)'(L);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t       state_q, state_d;
    logic [A-1:0] vs1_q, vs2_q, vd_q;
    logic [A:0]   vl_q, cnt_q;
    logic [A:0]   vl_clamped;
    logic         accept, issue, wr_inflight;

    // Write-back delay line: stage LAT-1 lines up with alu_result
    logic [LAT-1:0] wr_vld_p;
    logic [A-1:0]   wr_addr_p [LAT];

    always_comb begin
        vl_clamped = (vl > VL_MAX) ? VL_MAX : vl;
        accept     = (state_q == S_IDLE) && start;
        issue      = (state_q == S_ISSUE);
    end

    always_comb begin
        wr_inflight = 1'b0;
        for (int k = 0; k < LAT - 1; k++) begin
            wr_inflight = wr_inflight | wr_vld_p[k];
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = (vl_clamped == '0) ? S_DONE : S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (cnt_q + 1'b1 == vl_q) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // The last pending write goes out this cycle when no earlier stage holds one
                if (!wr_inflight) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Command latch and element counter; starts outside IDLE are dropped
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            vs1_q <= '0;
            vs2_q <= '0;
            vd_q  <= '0;
            vl_q  <= '0;
            cnt_q <= '0;
        end else if (accept) begin
            vs1_q <= vs1_base;
            vs2_q <= vs2_base;
            vd_q  <= vd_base;
            vl_q  <= vl_clamped;
            cnt_q <= '0;
        end else if (issue) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            wr_vld_p <= '0;
            for (int k = 0; k < LAT; k++) begin
                wr_addr_p[k] <= '0;
            end
        end else begin
            wr_vld_p[0]  <= issue;
            wr_addr_p[0] <= vd_q + cnt_q[A-1:0];
            for (int k = 1; k < LAT; k++) begin
                wr_vld_p[k]  <= wr_vld_p[k-1];
                wr_addr_p[k] <= wr_addr_p[k-1];
            end
        end
    end

    // Outputs are gated so idle or reset cycles present all zeros
    always_comb begin
        busy      = (state_q != S_IDLE);
        done      = (state_q == S_DONE);
        rf_write0 = 1'b0;
        rf_write1 = 1'b0;
        alu_valid = issue;
        rf_addr0  = issue ? vs1_q + cnt_q[A-1:0] : '0;
        rf_addr1  = issue ? vs2_q + cnt_q[A-1:0] : '0;
        alu_a     = issue ? rf_rdata0 : '0;
        alu_b     = issue ? rf_rdata1 : '0;
        rf_write2 = wr_vld_p[LAT-1];
        rf_addr2  = wr_vld_p[LAT-1] ? wr_addr_p[LAT-1] : '0;
        rf_wdata2 = wr_vld_p[LAT-1] ? alu_result : '0;
    end

endmodule

// File: tb/tb_vreg_elem_sequencer.sv
// Bench for vreg_elem_sequencer: behavioural register file and ALU around the DUT,
// with a cycle-accurate read/write scoreboard filled at each start.
module tb_vreg_elem_sequencer;

    localparam int W   = 16;
    localparam int L   = 32;
    localparam int A   = 5;
    localparam int LAT = 2;

    logic         clk = 1'b0;
    logic         n_reset;
    logic         start;
    logic [A-1:0] vs1_base, vs2_base, vd_base;
    logic [A:0]   vl;
    logic         busy, done;
    logic [A-1:0] rf_addr0, rf_addr1, rf_addr2;
    logic         rf_write0, rf_write1, rf_write2;
    logic [W-1:0] rf_rdata0, rf_rdata1, rf_wdata2;
    logic [W-1:0] alu_a, alu_b, alu_result;
    logic         alu_valid;

    vreg_elem_sequencer #(.W(W), .L(L), .A(A), .LAT(LAT)) dut (
        .clk(clk), .n_reset(n_reset), .start(start),
        .vs1_base(vs1_base), .vs2_base(vs2_base), .vd_base(vd_base), .vl(vl),
        .busy(busy), .done(done),
        .rf_addr0(rf_addr0), .rf_addr1(rf_addr1),
        .rf_write0(rf_write0), .rf_write1(rf_write1),
        .rf_rdata0(rf_rdata0), .rf_rdata1(rf_rdata1),
        .rf_addr2(rf_addr2), .rf_write2(rf_write2), .rf_wdata2(rf_wdata2),
        .alu_a(alu_a), .alu_b(alu_b), .alu_valid(alu_valid), .alu_result(alu_result)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Register file: combinational reads, write commits at the end of the write cycle
    logic [W-1:0] rf [L];
    logic         rf_loaded = 1'b0;
    assign rf_rdata0 = rf[rf_addr0];
    assign rf_rdata1 = rf[rf_addr1];
    always @(posedge clk) begin
        if (!rf_loaded) begin
            for (int k = 0; k < L; k++) rf[k] <= W'($urandom);
            rf_loaded <= 1'b1;
        end else if (rf_write2) begin
            rf[rf_addr2] <= rf_wdata2;
        end
    end

    // ALU: mode 0 adds, mode 1 passes operand a
    int           alu_mode = 0;
    logic [W-1:0] alu_pipe [LAT];
    always @(posedge clk) begin
        alu_pipe[0] <= alu_valid ? ((alu_mode == 0) ? alu_a + alu_b : alu_a) : '0;
        for (int k = 1; k < LAT; k++) alu_pipe[k] <= alu_pipe[k-1];
    end
    assign alu_result = alu_pipe[LAT-1];

    wire [68:0] all_outs = {busy, done, rf_addr0, rf_addr1, rf_addr2, rf_write0, rf_write1,
                            rf_write2, rf_wdata2, alu_a, alu_b, alu_valid};

    typedef struct {
        int           cyc;
        logic [A-1:0] a0;
        logic [A-1:0] a1;
        logic [W-1:0] da;
        logic [W-1:0] db;
    } rd_t;
    typedef struct {
        int           cyc;
        logic [A-1:0] addr;
        logic [W-1:0] data;
    } wr_t;

    rd_t rd_q[$];
    wr_t wr_q[$];
    int  n_checks = 0;
    int  n_fail   = 0;
    int  t0       = 0;
    int  wr_count = 0;
    int  vld_count = 0;

    // Scoreboard consumer: every operand cycle and write cycle is matched in order
    always @(negedge clk) begin
        rd_t r;
        wr_t w;
        if (n_reset) begin
            n_checks++;
            if (rf_write0 !== 1'b0 || rf_write1 !== 1'b0) begin
                n_fail++;
                $display("FAIL read_port_write: cycle %0d we0=%b we1=%b, required 0", cyc - t0, rf_write0, rf_write1);
            end
            if (alu_valid) begin
                vld_count++;
                n_checks++;
                if (rd_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_read: cycle %0d addr0=%0d addr1=%0d", cyc - t0, rf_addr0, rf_addr1);
                end else begin
                    r = rd_q.pop_front();
                    if (cyc !== r.cyc || rf_addr0 !== r.a0 || rf_addr1 !== r.a1 || alu_a !== r.da || alu_b !== r.db) begin
                        n_fail++;
                        $display("FAIL read_elem: got cyc %0d a0 %0d a1 %0d a %h b %h, required cyc %0d a0 %0d a1 %0d a %h b %h",
                                 cyc - t0, rf_addr0, rf_addr1, alu_a, alu_b, r.cyc - t0, r.a0, r.a1, r.da, r.db);
                    end
                end
            end
            if (rf_write2) begin
                wr_count++;
                n_checks++;
                if (wr_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_write: cycle %0d addr=%0d data=%h", cyc - t0, rf_addr2, rf_wdata2);
                end else begin
                    w = wr_q.pop_front();
                    if (cyc !== w.cyc || rf_addr2 !== w.addr || rf_wdata2 !== w.data) begin
                        n_fail++;
                        $display("FAIL write_elem: got cyc %0d addr %0d data %h, required cyc %0d addr %0d data %h",
                                 cyc - t0, rf_addr2, rf_wdata2, w.cyc - t0, w.addr, w.data);
                    end
                end
            end
        end
    end

    // Called right after a negedge; drives start for cycle 0 and returns at the cycle-1 negedge
    task automatic issue_start(input logic [A-1:0] s1, input logic [A-1:0] s2,
                               input logic [A-1:0] d, input logic [A:0] v);
        logic [W-1:0] m  [L];
        logic [A-1:0] wa [L];
        logic [W-1:0] wd [L];
        logic [W-1:0] a, b;
        int n;
        for (int k = 0; k < L; k++) m[k] = rf[k];
        n = (v > L) ? L : int'(v);
        t0 = cyc;
        wr_count = 0;
        vld_count = 0;
        for (int i = 0; i < n; i++) begin
            // Write of element j commits at the end of cycle 1+j+LAT, visible to reads from element j+LAT+1
            if (i - LAT - 1 >= 0) m[wa[i-LAT-1]] = wd[i-LAT-1];
            a = m[A'(s1 + i)];
            b = m[A'(s2 + i)];
            wa[i] = A'(d + i);
            wd[i] = (alu_mode == 0) ? W'(a + b) : a;
            rd_q.push_back('{t0 + 1 + i, A'(s1 + i), A'(s2 + i), a, b});
            wr_q.push_back('{t0 + 1 + i + LAT, wa[i], wd[i]});
        end
        vs1_base = s1;
        vs2_base = s2;
        vd_base  = d;
        vl       = v;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
    endtask

    task automatic wait_done(output int dcyc, output int bdrop, output int dpulses);
        dcyc = -1;
        bdrop = -1;
        dpulses = 0;
        for (int k = 0; k < 200; k++) begin
            if (done) begin
                dpulses++;
                if (dcyc < 0) dcyc = cyc - t0;
            end
            if (!busy) begin
                bdrop = cyc - t0;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic check_run(input string name, input int exp_done, input int exp_wr,
                             input int dcyc, input int bdrop, input int dpulses);
        n_checks++;
        if (dcyc !== exp_done || bdrop !== exp_done + 1 || dpulses !== 1) begin
            n_fail++;
            $display("FAIL %s_done: done cycle %0d busy-drop %0d pulses %0d, required %0d %0d 1",
                     name, dcyc, bdrop, dpulses, exp_done, exp_done + 1);
        end
        n_checks++;
        if (wr_count !== exp_wr || vld_count !== exp_wr || wr_q.size() != 0 || rd_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_count: writes %0d valids %0d left %0d/%0d, required %0d %0d 0/0",
                     name, wr_count, vld_count, wr_q.size(), rd_q.size(), exp_wr, exp_wr);
            wr_q.delete();
            rd_q.delete();
        end
    endtask

    task automatic test_reset;
        int dc, bd, dp;
        n_checks++;
        if (all_outs !== 69'd0) begin
            n_fail++;
            $display("FAIL reset_initial: outputs %h, required 0", all_outs);
        end
        n_reset = 1'b1;
        @(negedge clk);
        issue_start(5'd0, 5'd8, 5'd16, 6'd32);
        repeat (4) @(negedge clk);
        n_checks++;
        if (busy !== 1'b1 || alu_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_pre: busy %b alu_valid %b, required 1 1", busy, alu_valid);
        end
        #2 n_reset = 1'b0;
        #1;
        n_checks++;
        if (all_outs !== 69'd0) begin
            n_fail++;
            $display("FAIL reset_async: outputs %h, required 0", all_outs);
        end
        rd_q.delete();
        wr_q.delete();
        repeat (2) @(negedge clk);
        n_checks++;
        if (all_outs !== 69'd0) begin
            n_fail++;
            $display("FAIL reset_hold: outputs %h, required 0", all_outs);
        end
        n_reset = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || rf_write2 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: busy %b write %b, required 0 0", busy, rf_write2);
        end
        issue_start(5'd0, 5'd8, 5'd16, 6'd4);
        wait_done(dc, bd, dp);
        check_run("reset_rerun", 1 + 4 + LAT, 4, dc, bd, dp);
    endtask

    task automatic test_basic;
        int dc, bd, dp;
        alu_mode = 0;
        issue_start(5'd0, 5'd8, 5'd16, 6'd4);
        wait_done(dc, bd, dp);
        check_run("basic", 7, 4, dc, bd, dp);
    endtask

    task automatic test_wrap;
        int dc, bd, dp;
        alu_mode = 0;
        issue_start(5'd30, 5'd12, 5'd31, 6'd4);
        wait_done(dc, bd, dp);
        check_run("wrap", 7, 4, dc, bd, dp);
    endtask

    task automatic test_lengths;
        int dc, bd, dp;
        alu_mode = 0;
        issue_start(5'd3, 5'd4, 5'd5, 6'd0);
        wait_done(dc, bd, dp);
        check_run("vl0", 1, 0, dc, bd, dp);
        issue_start(5'd0, 5'd8, 5'd16, 6'd32);
        wait_done(dc, bd, dp);
        check_run("vl32", 35, 32, dc, bd, dp);
        issue_start(5'd0, 5'd8, 5'd16, 6'd40);
        wait_done(dc, bd, dp);
        check_run("vl40", 35, 32, dc, bd, dp);
    endtask

    task automatic test_back_to_back;
        int dc, bd, dp;
        alu_mode = 0;
        issue_start(5'd0, 5'd8, 5'd16, 6'd4);
        @(negedge clk);
        vs1_base = 5'd3;
        vs2_base = 5'd7;
        vd_base  = 5'd24;
        vl       = 6'd10;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        wait_done(dc, bd, dp);
        check_run("busy_start", 7, 4, dc, bd, dp);
        issue_start(5'd1, 5'd2, 5'd20, 6'd3);
        wait_done(dc, bd, dp);
        check_run("next_start", 6, 3, dc, bd, dp);
    endtask

    task automatic test_overlap;
        int dc, bd, dp;
        logic [W-1:0] old [L];
        alu_mode = 1;
        for (int k = 0; k < L; k++) old[k] = rf[k];
        issue_start(5'd0, 5'd0, 5'd1, 6'd4);
        wait_done(dc, bd, dp);
        check_run("overlap1", 7, 4, dc, bd, dp);
        n_checks++;
        if (rf[2] !== old[1] || rf[3] !== old[2] || rf[4] !== old[3]) begin
            n_fail++;
            $display("FAIL overlap1_data: rf2..4 %h %h %h, required %h %h %h",
                     rf[2], rf[3], rf[4], old[1], old[2], old[3]);
        end
        for (int k = 0; k < L; k++) old[k] = rf[k];
        issue_start(5'd0, 5'd0, 5'd3, 6'd8);
        wait_done(dc, bd, dp);
        check_run("overlap3", 11, 8, dc, bd, dp);
        n_checks++;
        if (rf[5] !== old[2] || rf[6] !== old[0] || rf[7] !== old[1]) begin
            n_fail++;
            $display("FAIL overlap3_data: rf5..7 %h %h %h, required %h %h %h",
                     rf[5], rf[6], rf[7], old[2], old[0], old[1]);
        end
    endtask

    initial begin
        n_reset  = 1'b0;
        start    = 1'b0;
        vs1_base = '0;
        vs2_base = '0;
        vd_base  = '0;
        vl       = '0;
        repeat (3) @(negedge clk);
        test_reset();
        test_basic();
        test_wrap();
        test_lengths();
        test_back_to_back();
        test_overlap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
